alu_shift_pipe: RTL and testbench
=================================

# alu_shift_pipe

Pipelined, parametrised shift/rotate unit for the execute stage of the simple processor. It supports logical and arithmetic shifts and rotates by a register or immediate amount, with a configurable number of register stages. A valid/ready handshake on both sides lets the unit accept a new operation every cycle and stall under downstream back-pressure. A tag travels with each operation so the writeback stage can match each result to its destination.

## Interface
- DATA_WIDTH, simple_processor_pkg::DATA_WIDTH (32): operand/result width; power of two, ≥ 4.
- PIPE_STAGES, 2: register stages between input and output; legal range 1..SHIFT_WIDTH.
- TAG_WIDTH, 5: width of the sideband tag (destination register index).
- SHIFT_WIDTH, localparam $clog2(DATA_WIDTH): shift-amount width.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  synchronous reset, active-low; sampled on the rising edge of clk_i.
- in_valid_i  input  1  operation present on the input.
- in_ready_o  output  1  unit accepts the operation this cycle.
- op_i  input  3  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5–7 illegal.
- use_imm_i  input  1  1: amount = imm_i; 0: amount = rs2_data_i[SHIFT_WIDTH-1:0].
- rs1_data_i  input  DATA_WIDTH  value to shift.
- rs2_data_i  input  DATA_WIDTH  register shift amount; upper bits are ignored.
- imm_i  input  SHIFT_WIDTH  immediate shift amount.
- tag_i  input  TAG_WIDTH  sideband tag, carried unchanged.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  DATA_WIDTH  shifted/rotated value.
- tag_o  output  TAG_WIDTH  tag of the result.
- illegal_o  output  1  op was illegal; result_o = rs1 unchanged.

## Operation
- Amount: amt = use_imm_i ? imm_i : rs2_data_i[SHIFT_WIDTH-1:0]. The amount is taken modulo DATA_WIDTH, so amt = 0 passes rs1 through for every op.
- SLL: zeros fill from the LSB.
- SRL: zeros fill from the MSB.
- SRA: copies of rs1[DATA_WIDTH-1] fill from the MSB.
- ROL/ROR: bits shifted out re-enter at the opposite end.
- Datapath is a log-shifter with SHIFT_WIDTH levels; level j shifts by 2^j when amt[j] = 1.
- Left ops are implemented by bit-reversing the input, performing a right operation, then reversing the output.
- Levels are split across PIPE_STAGES register stages: level j goes to stage floor(j*PIPE_STAGES/SHIFT_WIDTH).
- Each stage registers the following, each captured from the preceding stage (stage 0 captures from the inputs):
  - valid
  - partial data
  - remaining amount bits
  - op
  - tag
  - illegal
- Illegal op: no shift at any level; illegal_o = 1 with the result.
- Flow control is a global stall: adv = !out_valid_o || out_ready_i.
  - in_ready_o = adv.
  - When adv = 1, all stages shift forward one position; stage 0 loads in_valid_i && in_ready_o.
  - When adv = 0, all stage registers hold.
- Bubbles are not collapsed; an empty stage still waits for the stall to release.

## Timing
- Latency: an op accepted at edge N presents out_valid_o after edge N+PIPE_STAGES-1, i.e. it can be consumed at edge N+PIPE_STAGES, provided there is no stall.
- Throughput: one op per cycle while out_ready_i = 1.
- in_ready_o is combinational from out_valid_o and out_ready_i; no other input affects it.
- result_o, tag_o and illegal_o must hold stable while out_valid_o = 1 and out_ready_i = 0.
- Reset, while rst_ni = 0 at an edge:
  - all stage valids clear, so out_valid_o = 0;
  - result_o = 0, tag_o = 0, illegal_o = 0;
  - in_ready_o = 1 combinationally (since out_valid_o = 0).
- Reset mid-operation discards all in-flight ops; nothing is emitted afterwards.
- Simultaneous consume and accept in the same cycle is legal and loses no op.
- in_valid_i while in_ready_o = 0 is not accepted; the source must hold its inputs.
- PIPE_STAGES = SHIFT_WIDTH gives one level per stage; PIPE_STAGES = 1 gives all levels in one stage.

## Test plan
- **Shift ops** (DATA_WIDTH = 32, PIPE_STAGES = 2, out_ready = 1), each expected 2 cycles after acceptance:
  - SLL rs1 = 0x00000003, rs2 = 31 → 0x80000000.
  - SRL 0x80000000 by 4 → 0x08000000.
  - SRA 0x80000000 by 4 → 0xF8000000.
- **Rotates and immediates**:
  - ROR 0x00000001, imm = 1, use_imm = 1 → 0x80000000.
  - ROL 0x80000001 by 4 → 0x00000018.
  - rs2 = 0x00000024 (36) with SRL → shift by 4, since only the low 5 bits are used.
- **Corners**:
  - amt = 0 for all five ops → rs1 unchanged.
  - op = 6 → illegal_o = 1, result = rs1.
- **Back-pressure**: stream 8 tagged ops while toggling out_ready_i randomly.
  - Results appear in order, tags 0..7, with correct values.
  - Outputs stay stable while stalled; no op is dropped or duplicated; in_ready_o = 0 exactly when out_valid_o = 1 and out_ready_i = 0.
- **Reset mid-flight**: with 2 ops in flight, drive rst_ni = 0 for 1 cycle.
  - out_valid_o = 0 and all outputs = 0 on the next cycle.
  - No stale result ever appears; a new op after reset completes with the normal latency.
- **Parameter sweep**: DATA_WIDTH ∈ {8, 32, 64} × PIPE_STAGES ∈ {1, SHIFT_WIDTH}.
  - Random ops are checked against a reference model.
  - Measured latency equals PIPE_STAGES.

Source files
------------

// File: rtl/alu_shift_pipe.sv
// rtl/alu_shift_pipe.sv - pipelined log-shifter for shifts and rotates with valid/ready flow control
package simple_processor_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module alu_shift_pipe #(
    parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH   = 5,
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [2:0]             op_i,
    input  logic                   use_imm_i,
    input  logic [DATA_WIDTH-1:0]  rs1_data_i,
    input  logic [DATA_WIDTH-1:0]  rs2_data_i,
    input  logic [SHIFT_WIDTH-1:0] imm_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   illegal_o
);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // Left ops travel through the pipe bit-reversed so only right shifters are needed.
    function automatic logic is_left(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_ROL);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = d[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    // Applies the log-shifter levels owned by one stage; level j moves by 2^j when amt[j] is set.
    function automatic logic [DATA_WIDTH-1:0] shift_levels(
        input logic [DATA_WIDTH-1:0]  d,
        input logic [SHIFT_WIDTH-1:0] amt,
        input logic [2:0]             op,
        input logic                   ill,
        input int                     stage
    );
        logic [DATA_WIDTH-1:0] r;
        r = d;
        for (int j = 0; j < SHIFT_WIDTH; j++) begin
            if (!ill && amt[j] && ((j * PIPE_STAGES) / SHIFT_WIDTH == stage)) begin
                case (op)
                    OP_SRA:         r = $unsigned($signed(r) >>> (1 << j));
                    OP_ROL, OP_ROR: r = (r >> (1 << j)) | (r << (DATA_WIDTH - (1 << j)));
                    default:        r = r >> (1 << j);
                endcase
            end
        end
        return r;
    endfunction

    logic adv;
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic                   v_q;
        logic                   ill_q;
        logic [DATA_WIDTH-1:0]  data_q;
        logic [SHIFT_WIDTH-1:0] amt_q;
        logic [2:0]             op_q;
        logic [TAG_WIDTH-1:0]   tag_q;

        logic                   v_d;
        logic                   ill_d;
        logic [DATA_WIDTH-1:0]  data_src;
        logic [DATA_WIDTH-1:0]  data_d;
        logic [SHIFT_WIDTH-1:0] amt_d;
        logic [2:0]             op_d;
        logic [TAG_WIDTH-1:0]   tag_d;

        if (s == 0) begin : g_head
            assign v_d      = in_valid_i && in_ready_o;
            assign data_src = is_left(op_i) ? bit_rev(rs1_data_i) : rs1_data_i;
            assign amt_d    = use_imm_i ? imm_i : rs2_data_i[SHIFT_WIDTH-1:0];
            assign op_d     = op_i;
            assign tag_d    = tag_i;
            assign ill_d    = (op_i > OP_ROR);
        end else begin : g_body
            assign v_d      = g_stage[s-1].v_q;
            assign data_src = g_stage[s-1].data_q;
            assign amt_d    = g_stage[s-1].amt_q;
            assign op_d     = g_stage[s-1].op_q;
            assign tag_d    = g_stage[s-1].tag_q;
            assign ill_d    = g_stage[s-1].ill_q;
        end

        assign data_d = shift_levels(data_src, amt_d, op_d, ill_d, s);

        // Stage register: clears on reset, advances only when the whole pipe may move.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                v_q    <= 1'b0;
                ill_q  <= 1'b0;
                data_q <= '0;
                amt_q  <= '0;
                op_q   <= '0;
                tag_q  <= '0;
            end else if (adv) begin
                v_q    <= v_d;
                ill_q  <= ill_d;
                data_q <= data_d;
                amt_q  <= amt_d;
                op_q   <= op_d;
                tag_q  <= tag_d;
            end
        end
    end

    assign out_valid_o = g_stage[PIPE_STAGES-1].v_q;
    assign result_o    = is_left(g_stage[PIPE_STAGES-1].op_q) ? bit_rev(g_stage[PIPE_STAGES-1].data_q)
                                                              : g_stage[PIPE_STAGES-1].data_q;
    assign tag_o       = g_stage[PIPE_STAGES-1].tag_q;
    assign illegal_o   = g_stage[PIPE_STAGES-1].ill_q;

    // Amount bits above the shift width and the final stage's amount carry no meaning.
    logic unused_bits;
    if (SHIFT_WIDTH < DATA_WIDTH) begin : g_unused
        assign unused_bits = ^{rs2_data_i[DATA_WIDTH-1:SHIFT_WIDTH], g_stage[PIPE_STAGES-1].amt_q};
    end else begin : g_unused_amt
        assign unused_bits = ^g_stage[PIPE_STAGES-1].amt_q;
    end

endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb/tb_alu_shift_pipe.sv - self-checking bench for alu_shift_pipe
module tb_alu_shift_pipe;

    localparam int NSW = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, use_imm, out_valid, out_ready, illegal;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  imm, tag, tag_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_shift_pipe #(.DATA_WIDTH(32), .PIPE_STAGES(2), .TAG_WIDTH(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .use_imm_i(use_imm), .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm),
        .tag_i(tag), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .tag_o(tag_out), .illegal_o(illegal)
    );

    function automatic int sw_dw(input int i);
        case (i / 2)
            0:       return 8;
            1:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_ps(input int i);
        return (i % 2 == 0) ? 1 : $clog2(sw_dw(i));
    endfunction

    logic                     sw_vin, sw_use_imm;
    logic [63:0]              sw_rs1, sw_rs2;
    logic [5:0]               sw_imm;
    logic [2:0]               sw_op;
    logic [NSW-1:0]           sw_vout, sw_rdy, sw_ill;
    logic [NSW-1:0][63:0]     sw_res;
    logic [NSW-1:0][4:0]      sw_tag;

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int W = sw_dw(g);
        localparam int P = sw_ps(g);
        localparam int S = $clog2(W);
        logic [W-1:0] res;
        alu_shift_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(P), .TAG_WIDTH(5)) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .in_valid_i(sw_vin), .in_ready_o(sw_rdy[g]),
            .op_i(sw_op), .use_imm_i(sw_use_imm), .rs1_data_i(sw_rs1[W-1:0]),
            .rs2_data_i(sw_rs2[W-1:0]), .imm_i(sw_imm[S-1:0]), .tag_i(5'(g)),
            .out_valid_o(sw_vout[g]), .out_ready_i(1'b1), .result_o(res),
            .tag_o(sw_tag[g]), .illegal_o(sw_ill[g])
        );
        assign sw_res[g] = 64'(res);
    end

    // Reference: plain arithmetic on a w-bit value, amount reduced modulo w.
    function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input int opc, input int amt, input int w);
        logic [63:0] mask, a, r;
        int n;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        n = amt % w;
        case (opc)
            0: r = a << n;
            1: r = a >> n;
            2: begin
                r = a >> n;
                if (a[w-1]) r = r | (mask & ~(mask >> n));
            end
            3: r = (a << n) | (a >> (w - n));
            4: r = (a >> n) | (a << (w - n));
            default: r = a;
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic ui, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] im, input logic [4:0] t,
                          input logic [31:0] exp, input logic exp_ill);
        in_valid = 1'b1; out_ready = 1'b1;
        op = o; use_imm = ui; rs1 = a; rs2 = b; imm = im; tag = t;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_lat_early"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_result"}, 64'(result), 64'(exp));
        chk({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
        chk({name, "_tag"}, 64'(tag_out), 64'(t));
        @(posedge clk); #1;
        chk({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    logic [31:0] bp_rs1 [8];
    logic [31:0] bp_rs2 [8];
    logic [4:0]  bp_imm [8];
    logic        bp_ui  [8];
    int          bp_op  [8];

    initial begin
        int sent, recv, amt_raw;
        logic stalled;
        logic [31:0] hold_res;
        logic [4:0] hold_tag;
        logic [63:0] exp;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; use_imm = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; tag = '0;
        sw_vin = 1'b0; sw_use_imm = 1'b0; sw_rs1 = '0; sw_rs2 = '0; sw_imm = '0; sw_op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_tag", 64'(tag_out), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("sll31", 3'd0, 1'b0, 32'h0000_0003, 32'd31, 5'd0, 5'd1, 32'h8000_0000, 1'b0);
        run_op("srl4", 3'd1, 1'b0, 32'h8000_0000, 32'd4, 5'd0, 5'd2, 32'h0800_0000, 1'b0);
        run_op("sra4", 3'd2, 1'b0, 32'h8000_0000, 32'd4, 5'd0, 5'd3, 32'hF800_0000, 1'b0);
        run_op("ror_imm1", 3'd4, 1'b1, 32'h0000_0001, 32'd0, 5'd1, 5'd4, 32'h8000_0000, 1'b0);
        run_op("rol4", 3'd3, 1'b0, 32'h8000_0001, 32'd4, 5'd0, 5'd5, 32'h0000_0018, 1'b0);
        run_op("srl_rs2_36", 3'd1, 1'b0, 32'h8000_0000, 32'h0000_0024, 5'd0, 5'd6, 32'h0800_0000, 1'b0);
        for (int o = 0; o < 5; o++) begin
            run_op("amt0", 3'(o), 1'b0, 32'hA5C3_0F96, 32'h0000_0020, 5'd0, 5'(o), 32'hA5C3_0F96, 1'b0);
        end
        run_op("illegal6", 3'd6, 1'b0, 32'h1234_5678, 32'd3, 5'd0, 5'd7, 32'h1234_5678, 1'b1);

        // Back-pressure stream of 8 tagged ops with random consumer readiness.
        for (int i = 0; i < 8; i++) begin
            bp_rs1[i] = $urandom; bp_rs2[i] = $urandom; bp_imm[i] = 5'($urandom);
            bp_ui[i] = 1'($urandom); bp_op[i] = $urandom_range(0, 5);
        end
        sent = 0; recv = 0; stalled = 1'b0; hold_res = '0; hold_tag = '0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1; op = 3'(bp_op[sent]); rs1 = bp_rs1[sent]; rs2 = bp_rs2[sent];
                imm = bp_imm[sent]; use_imm = bp_ui[sent]; tag = 5'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (stalled) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_result", 64'(result), 64'(hold_res));
                chk("bp_hold_tag", 64'(tag_out), 64'(hold_tag));
            end
            if (out_valid && out_ready) begin
                amt_raw = bp_ui[recv] ? int'(bp_imm[recv]) : int'(bp_rs2[recv][4:0]);
                exp = ref_shift(64'(bp_rs1[recv]), bp_op[recv], amt_raw, 32);
                chk("bp_result", 64'(result), exp);
                chk("bp_tag", 64'(tag_out), 64'(recv));
                chk("bp_illegal", 64'(illegal), 64'(bp_op[recv] >= 5));
                recv++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1; hold_res = result; hold_tag = tag_out;
            end else begin
                stalled = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        chk("bp_count", 64'(recv), 64'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_no_extra", 64'(out_valid), 64'd0);
        end

        // Reset with two ops in flight.
        in_valid = 1'b1; op = 3'd1; use_imm = 1'b1; rs1 = 32'hFFFF_0000; imm = 5'd8; tag = 5'd9;
        @(posedge clk); #1;
        op = 3'd0; rs1 = 32'h0000_FFFF; tag = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_inflight", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_tag", 64'(tag_out), 64'd0);
        chk("mid_rst_illegal", 64'(illegal), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("mid_no_stale", 64'(out_valid), 64'd0);
        end
        run_op("post_rst", 3'd2, 1'b0, 32'h8000_00F0, 32'd8, 5'd0, 5'd11, 32'hFF80_0000, 1'b0);

        // Parameter sweep: random single ops, latency and value per instance.
        for (int t = 0; t < 24; t++) begin
            sw_rs1 = {$urandom, $urandom}; sw_rs2 = {$urandom, $urandom};
            sw_imm = 6'($urandom); sw_op = 3'($urandom_range(0, 7)); sw_use_imm = 1'($urandom);
            sw_vin = 1'b1;
            #1;
            for (int i = 0; i < NSW; i++) chk("sw_in_ready", 64'(sw_rdy[i]), 64'd1);
            @(posedge clk); #1;
            sw_vin = 1'b0;
            for (int k = 0; k < 7; k++) begin
                for (int i = 0; i < NSW; i++) begin
                    chk("sw_latency", 64'(sw_vout[i]), 64'(k == sw_ps(i) - 1));
                    if (k == sw_ps(i) - 1) begin
                        amt_raw = sw_use_imm ? int'(sw_imm) : int'(sw_rs2[5:0]);
                        chk("sw_result", sw_res[i], ref_shift(sw_rs1, int'(sw_op), amt_raw, sw_dw(i)));
                        chk("sw_illegal", 64'(sw_ill[i]), 64'(sw_op >= 3'd5));
                        chk("sw_tag", 64'(sw_tag[i]), 64'(i));
                    end
                end
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
